duty_ramp: RTL
==============

DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 SHALL have parameter STEP, default 16, meaning the duty change per PWM period (1..2047).
REQ-002 SHALL have parameter DEAD_PERIODS, default 2, meaning the number of full PWM periods held at zero duty before a direction flip (1..15).
REQ-003 SHALL have port clk  input  1  meaning the single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the asynchronous, active-low reset.
REQ-005 SHALL have port tgt_spd  input  12  meaning the signed two's-complement target speed, where positive means forward.
REQ-006 SHALL have port tgt_vld  input  1  meaning tgt_spd is valid this cycle.
REQ-007 SHALL have port tgt_rdy  output  1  meaning the block accepts a target this cycle.
REQ-008 SHALL have port duty  output  11  meaning the registered duty magnitude that feeds the 11-bit PWM generator.
REQ-009 SHALL have port fwd  output  1  meaning the registered direction, where 1 is forward.
REQ-010 SHALL have port at_tgt  output  1  meaning the registered level that is high when duty equals the target magnitude and fwd matches the target sign.

Function
REQ-011 SHALL run a free-running 11-bit period counter that starts at 0 after reset and wraps 2047->0; tick is the cycle where the counter equals 2047.
REQ-012 SHALL update duty, fwd and state only on tick cycles, so new values appear when the counter is 0, aligned with the wrap of the downstream PWM counter.
REQ-013 SHALL accept a target when tgt_vld and tgt_rdy are both high.
REQ-014 SHALL drive tgt_rdy high in every state except DEAD.
REQ-015 SHALL compute the target magnitude as |tgt_spd|, saturating -2048 to 2047.
REQ-016 SHALL compute the target direction as 1 for tgt_spd >= 0; a zero target keeps the current fwd.
REQ-017 SHALL hold exactly one pending target; a later accept overwrites it, and a target accepted on a tick cycle takes effect at the next tick.
REQ-018 SHALL implement states IDLE, RAMP, HOLD, DECEL and DEAD.
REQ-019 In IDLE, duty SHALL be 0; on a tick with a nonzero pending target, go to RAMP if the direction matches, else DECEL.
REQ-020 In RAMP, each tick SHALL set duty to min(duty+STEP, tgt) when rising, else max(duty-STEP, tgt), with no overflow beyond 2047 or underflow below 0; go to HOLD when duty reaches tgt.
REQ-021 In HOLD, duty SHALL be held; a new target with the same direction goes to RAMP, one with the opposite direction goes to DECEL, and a zero target goes to RAMP and then to IDLE when duty reaches 0.
REQ-022 In DECEL, each tick SHALL apply duty=max(duty-STEP,0); when duty reaches 0, go to DEAD.
REQ-023 In DEAD, duty SHALL stay 0 for DEAD_PERIODS ticks; on the last tick, invert fwd and go to RAMP.
REQ-024 A target accepted during DECEL SHALL update the pending target; if its direction matches the current fwd, go to RAMP instead of continuing DECEL.
REQ-025 fwd SHALL never change while duty is nonzero.
REQ-026 at_tgt SHALL be low whenever the state is DECEL or DEAD.

Reset
REQ-027 On rst_n low, the block SHALL immediately force duty=0, fwd=1, at_tgt=1 (target zero), tgt_rdy=0, state=IDLE, period counter=0 and pending target=0, including mid-ramp.
REQ-028 tgt_rdy SHALL rise on the first clock after rst_n deasserts.

Configuration
REQ-029 With the macro DUTY_RAMP_ESTOP_EN defined, the block SHALL add input estop (1 bit); when estop is high, on the next clock edge regardless of tick, duty SHALL become 0, state IDLE, the pending target 0, and tgt_rdy low while estop is held.
REQ-030 Without DUTY_RAMP_ESTOP_EN, the block SHALL have no estop port and no estop logic.

Structure
REQ-031 Shared package duty_ramp_pkg SHALL hold the state enum typedef, the constant PERIOD_W=11 and the constant DUTY_MAX=2047.
REQ-032 The period counter and tick generation SHALL be a sub-module named pwm_period_tmr with ports clk, rst_n, tick.

Verification
REQ-033 Ramp up: STEP=16, accept +160 from IDLE -> duty takes 16,32,...,160 on 10 consecutive ticks, fwd=1, at_tgt rises with duty=160, state HOLD.
REQ-034 Reversal: from HOLD at +160, accept -64 -> duty falls 144..0 over 10 ticks, 2 periods at 0, fwd goes 0, then duty takes 16,32,48,64, and fwd never toggles while duty is nonzero.
REQ-035 Saturation: accept -2048 -> the final duty is 2047, fwd=0, and there is no wrap on the last partial step (2032->2047).
REQ-036 Tick collision: accept +32 on a tick cycle, then +48 two cycles later -> duty follows the +48 ramp and never settles at 32.
REQ-037 Reset mid-ramp: assert rst_n low at duty=80 -> duty=0 and fwd=1 asynchronously, and the period counter restarts at 0.
REQ-038 Estop (with DUTY_RAMP_ESTOP_EN): pulse estop at duty=2000 mid-period -> duty=0 on the next clock edge, state IDLE, and tgt_rdy low during the pulse.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// Shared types and constants for the duty_ramp controller and its period timer.
package duty_ramp_pkg;

  localparam int PERIOD_W = 11;
  localparam int DUTY_MAX = 2047;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    DECEL,
    DEAD
  } state_t;

  // Absolute value of a 12-bit signed speed; -2048 has no positive twin, so it clamps.
  function automatic logic [10:0] sat_mag(input logic [11:0] spd);
    if (!spd[11]) begin
      return spd[10:0];
    end else if (spd == 12'h800) begin
      return 11'(DUTY_MAX);
    end else begin
      return 11'(12'd0 - spd);
    end
  endfunction

endpackage

// File: rtl/duty_ramp_pwm_period_tmr.sv
// Free-running PWM period counter; tick marks the last cycle of each period.
module pwm_period_tmr
  import duty_ramp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  logic [PERIOD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = &cnt;

endmodule

// File: rtl/duty_ramp.sv
// duty_ramp: slew-limited PWM duty controller with dead-time direction reversal.
// Optional emergency stop input is enabled by defining DUTY_RAMP_ESTOP_EN.
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int STEP         = 16,
  parameter int DEAD_PERIODS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] tgt_spd,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  output logic [10:0] duty,
  output logic        fwd,
  output logic        at_tgt
`ifdef DUTY_RAMP_ESTOP_EN
  ,
  input  logic        estop
`endif
);

  localparam logic [11:0] STEP_X    = 12'(STEP);
  localparam logic [3:0]  DEAD_LAST = 4'(DEAD_PERIODS - 1);

  state_t      state, state_next;
  logic [10:0] duty_next, pend_mag, pend_mag_next, ramp_duty, decel_duty;
  logic        fwd_next, at_tgt_next, pend_dir, pend_dir_next;
  logic        rdy, rdy_next, tick, reverse;
  logic [3:0]  dead_cnt, dead_next;
  logic [11:0] up_sum, dn_diff;

  pwm_period_tmr u_tmr (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // One extra bit keeps the step arithmetic free of wrap; bit 11 of dn_diff is the borrow.
  assign up_sum     = {1'b0, duty} + STEP_X;
  assign dn_diff    = {1'b0, duty} - STEP_X;
  assign decel_duty = dn_diff[11] ? '0 : dn_diff[10:0];
  assign reverse    = (pend_mag != '0) && (pend_dir != fwd);

  always_comb begin
    if (duty < pend_mag) begin
      ramp_duty = (up_sum > {1'b0, pend_mag}) ? pend_mag : up_sum[10:0];
    end else begin
      ramp_duty = (dn_diff[11] || (dn_diff[10:0] < pend_mag)) ? pend_mag : dn_diff[10:0];
    end
  end

`ifdef DUTY_RAMP_ESTOP_EN
  assign tgt_rdy = rdy & ~estop;
`else
  assign tgt_rdy = rdy;
`endif

  always_comb begin
    state_next    = state;
    duty_next     = duty;
    fwd_next      = fwd;
    dead_next     = dead_cnt;
    pend_mag_next = pend_mag;
    pend_dir_next = pend_dir;

    if (tgt_vld && tgt_rdy) begin
      pend_mag_next = sat_mag(tgt_spd);
      pend_dir_next = ~tgt_spd[11];
    end

    // The tick decision uses the pending target as it stood before this cycle's accept.
    if (tick) begin
      if ((state == DEAD) && (dead_cnt != DEAD_LAST)) begin
        dead_next = dead_cnt + 4'd1;
      end else if ((state != DEAD) && reverse) begin
        duty_next  = decel_duty;
        dead_next  = '0;
        state_next = (decel_duty == '0) ? DEAD : DECEL;
      end else begin
        if (state == DEAD) begin
          fwd_next = ~fwd;
        end
        duty_next = ramp_duty;
        if (ramp_duty != pend_mag) begin
          state_next = RAMP;
        end else if (pend_mag == '0) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
    end

`ifdef DUTY_RAMP_ESTOP_EN
    if (estop) begin
      state_next    = IDLE;
      duty_next     = '0;
      dead_next     = '0;
      pend_mag_next = '0;
    end
`endif

    rdy_next    = (state_next != DEAD);
    at_tgt_next = (state_next != DECEL) && (state_next != DEAD) &&
                  (duty_next == pend_mag_next) &&
                  ((pend_mag_next == '0) || (pend_dir_next == fwd_next));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty     <= '0;
      fwd      <= 1'b1;
      at_tgt   <= 1'b1;
      rdy      <= 1'b0;
      pend_mag <= '0;
      pend_dir <= 1'b1;
      dead_cnt <= '0;
    end else begin
      state    <= state_next;
      duty     <= duty_next;
      fwd      <= fwd_next;
      at_tgt   <= at_tgt_next;
      rdy      <= rdy_next;
      pend_mag <= pend_mag_next;
      pend_dir <= pend_dir_next;
      dead_cnt <= dead_next;
    end
  end

endmodule
